// File: rtl/cond_pkg.sv
// Shared definitions for the execute-stage conditional-execution unit:
// condition codes, NZCV bit positions and the execute-control word.
package cond_pkg;

  // ARM condition field encodings (instruction bits [31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the {N,Z,C,V} flag nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Control word carried from decode into the execute register
  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowrite;
    logic [1:0] flagw;
    logic [3:0] cond;
  } ectrl_t;

  localparam int ECTRL_W = $bits(ectrl_t);

  // A bubble does nothing and always passes its (AL) condition
  localparam ectrl_t ECTRL_BUBBLE = '{
    pcs:     1'b0,
    regw:    1'b0,
    memw:    1'b0,
    nowrite: 1'b0,
    flagw:   2'b00,
    cond:    COND_AL
  };

endpackage

// File: rtl/cond_if.sv
// Bundle of the decode-side controls, the pipeline stall/flush controls,
// the ALU flag input and the gated execute-stage outputs of cond_unit.
interface cond_if;
  logic       stall_e;
  logic       flush_e;
  logic       PCS_D;
  logic       RegW_D;
  logic       MemW_D;
  logic       NoWrite_D;
  logic [1:0] FlagW_D;
  logic [3:0] Cond_D;
  logic [3:0] ALUFlags;
  logic       PCSrc_E;
  logic       RegWrite_E;
  logic       MemWrite_E;
  logic       CondEx_E;
  logic [3:0] Flags;

  // Pipeline/decoder side: drives controls, observes gated outputs
  modport master (
    output stall_e, flush_e, PCS_D, RegW_D, MemW_D, NoWrite_D, FlagW_D,
           Cond_D, ALUFlags,
    input  PCSrc_E, RegWrite_E, MemWrite_E, CondEx_E, Flags
  );

  // Conditional-execution unit side
  modport slave (
    input  stall_e, flush_e, PCS_D, RegW_D, MemW_D, NoWrite_D, FlagW_D,
           Cond_D, ALUFlags,
    output PCSrc_E, RegWrite_E, MemWrite_E, CondEx_E, Flags
  );
endinterface

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: does Cond pass for the
// given {N,Z,C,V}? Code 1111 is treated as always.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = Flags[FLAG_N];
  assign z_s = Flags[FLAG_Z];
  assign c_s = Flags[FLAG_C];
  assign v_s = Flags[FLAG_V];

  // Decode the condition field against the flag bits
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z_s;
      COND_NE: CondEx = ~z_s;
      COND_CS: CondEx = c_s;
      COND_CC: CondEx = ~c_s;
      COND_MI: CondEx = n_s;
      COND_PL: CondEx = ~n_s;
      COND_VS: CondEx = v_s;
      COND_VC: CondEx = ~v_s;
      COND_HI: CondEx = c_s & ~z_s;
      COND_LS: CondEx = ~c_s | z_s;
      COND_GE: CondEx = (n_s == v_s);
      COND_LT: CondEx = (n_s != v_s);
      COND_GT: CondEx = ~z_s & (n_s == v_s);
      COND_LE: CondEx = z_s | (n_s != v_s);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage conditional-execution unit: execute control register with
// stall/flush, committed NZCV flag register, condition check and gating of
// the PC, register-file and memory write enables.
module cond_unit
  import cond_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  cond_if.slave  bus
);

  ectrl_t     d_s;
  ectrl_t     e_r;
  ectrl_t     e_next_s;
  logic [3:0] flags_r;
  logic [3:0] flags_next_s;
  logic       condex_s;
  logic       retire_s;

  assign d_s = '{
    pcs:     bus.PCS_D,
    regw:    bus.RegW_D,
    memw:    bus.MemW_D,
    nowrite: bus.NoWrite_D,
    flagw:   bus.FlagW_D,
    cond:    bus.Cond_D
  };

  // Next execute control word: flush beats stall, stall holds, else capture
  always_comb begin
    e_next_s = e_r;
    if (bus.flush_e) begin
      e_next_s = ECTRL_BUBBLE;
    end else if (bus.stall_e) begin
      e_next_s = e_r;
    end else begin
      e_next_s = d_s;
    end
  end

  // Execute control register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_r <= ECTRL_BUBBLE;
    end else begin
      e_r <= e_next_s;
    end
  end

  cond_check u_cond_check (
    .Cond   (e_r.cond),
    .Flags  (flags_r),
    .CondEx (condex_s)
  );

  // The E instruction retires whenever it is not stalled; a stall+flush
  // discards it, so flush alone never blocks a commit.
  assign retire_s = ~bus.stall_e & condex_s;

  // Next flags: a passing, retiring instruction updates the selected halves
  always_comb begin
    flags_next_s = flags_r;
    if (retire_s) begin
      if (e_r.flagw[1]) begin
        flags_next_s[FLAG_N] = bus.ALUFlags[FLAG_N];
        flags_next_s[FLAG_Z] = bus.ALUFlags[FLAG_Z];
      end else begin
        flags_next_s[FLAG_N] = flags_r[FLAG_N];
        flags_next_s[FLAG_Z] = flags_r[FLAG_Z];
      end
      if (e_r.flagw[0]) begin
        flags_next_s[FLAG_C] = bus.ALUFlags[FLAG_C];
        flags_next_s[FLAG_V] = bus.ALUFlags[FLAG_V];
      end else begin
        flags_next_s[FLAG_C] = flags_r[FLAG_C];
        flags_next_s[FLAG_V] = flags_r[FLAG_V];
      end
    end else begin
      flags_next_s = flags_r;
    end
  end

  // Committed architectural flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= flags_next_s;
    end
  end

  // Outputs are register bits qualified only by the condition result, so
  // they stay asserted while an enabled instruction is held by a stall.
  assign bus.CondEx_E   = condex_s;
  assign bus.PCSrc_E    = e_r.pcs & condex_s;
  assign bus.RegWrite_E = e_r.regw & ~e_r.nowrite & condex_s;
  assign bus.MemWrite_E = e_r.memw & condex_s;
  assign bus.Flags      = flags_r;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit with a behavioural model of the
// execute register and NZCV flags.
module tb_cond_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  cond_if bus ();

  cond_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit       m_pcs, m_regw, m_memw, m_nowr;
  bit [1:0] m_flagw;
  bit [3:0] m_cond;
  bit [3:0] m_flags;

  // ARM rule: even code selects a base test, odd code inverts it (except 111x)
  function automatic bit mcond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) r = !r;
    return r;
  endfunction

  function automatic bit exp_condex();
    return mcond(m_cond, m_flags);
  endfunction
  function automatic bit exp_pcsrc();
    return m_pcs && mcond(m_cond, m_flags);
  endfunction
  function automatic bit exp_regwrite();
    return m_regw && !m_nowr && mcond(m_cond, m_flags);
  endfunction
  function automatic bit exp_memwrite();
    return m_memw && mcond(m_cond, m_flags);
  endfunction

  task automatic model_reset();
    m_pcs = 0; m_regw = 0; m_memw = 0; m_nowr = 0; m_flagw = 2'b00;
    m_cond = 4'b1110; m_flags = 4'b0000;
  endtask

  task automatic drive(input bit pcs, input bit regw, input bit memw,
                       input bit nowr, input bit [1:0] fw, input bit [3:0] c);
    bus.PCS_D = pcs; bus.RegW_D = regw; bus.MemW_D = memw;
    bus.NoWrite_D = nowr; bus.FlagW_D = fw; bus.Cond_D = c;
  endtask

  // One clock: model follows the rules, then outputs settle #1 after the edge
  task automatic tick();
    bit [3:0] nf;
    bit       ce;
    ce = mcond(m_cond, m_flags);
    nf = m_flags;
    if (!bus.stall_e && ce) begin
      if (m_flagw[1]) nf[3:2] = bus.ALUFlags[3:2];
      if (m_flagw[0]) nf[1:0] = bus.ALUFlags[1:0];
    end
    @(posedge clk);
    m_flags = nf;
    if (bus.flush_e) begin
      m_pcs = 0; m_regw = 0; m_memw = 0; m_nowr = 0; m_flagw = 2'b00; m_cond = 4'b1110;
    end else if (!bus.stall_e) begin
      m_pcs = bus.PCS_D; m_regw = bus.RegW_D; m_memw = bus.MemW_D;
      m_nowr = bus.NoWrite_D; m_flagw = bus.FlagW_D; m_cond = bus.Cond_D;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.stall_e = 0; bus.flush_e = 0;
    drive(0, 0, 0, 0, 2'b11, 4'b1110); bus.ALUFlags = 4'b1111;
    tick();
    drive(1, 1, 1, 0, 2'b00, 4'b1110);
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.Flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", bus.Flags); else n_pass++;
    n_checks++; if (bus.CondEx_E !== 1'b1) $display("FAIL reset_condex: got %b want 1", bus.CondEx_E); else n_pass++;
    n_checks++; if (bus.PCSrc_E !== 1'b0) $display("FAIL reset_pcsrc: got %b want 0", bus.PCSrc_E); else n_pass++;
    n_checks++; if (bus.RegWrite_E !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite_E); else n_pass++;
    n_checks++; if (bus.MemWrite_E !== 1'b0) $display("FAIL reset_memwrite: got %b want 0", bus.MemWrite_E); else n_pass++;
    drive(0, 0, 0, 0, 2'b00, 4'b1110);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_cond_sweep();
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(0, 1, 0, 0, 2'b11, 4'b1110);
        bus.ALUFlags = 4'(f);
        tick();
        drive(0, 1, 0, 0, 2'b00, 4'(c));
        tick();
        n_checks++;
        if (bus.Flags !== 4'(f)) $display("FAIL sweep_flags c=%0d: got %b want %b", c, bus.Flags, 4'(f));
        else n_pass++;
        n_checks++;
        if (bus.RegWrite_E !== exp_regwrite())
          $display("FAIL sweep_regwrite c=%b f=%b: got %b want %b", 4'(c), 4'(f), bus.RegWrite_E, exp_regwrite());
        else n_pass++;
      end
    end
  endtask

  task automatic test_subs_beq();
    drive(0, 1, 0, 0, 2'b11, 4'b1110); bus.ALUFlags = 4'b0100;
    tick();
    drive(1, 0, 0, 0, 2'b00, 4'b0000);
    tick();
    n_checks++; if (bus.Flags !== 4'b0100) $display("FAIL subs_flags: got %b want 0100", bus.Flags); else n_pass++;
    n_checks++; if (bus.PCSrc_E !== 1'b1) $display("FAIL beq_pcsrc: got %b want 1", bus.PCSrc_E); else n_pass++;
  endtask

  task automatic test_cmp_nowrite();
    drive(0, 1, 0, 1, 2'b11, 4'b1110); bus.ALUFlags = 4'b1000;
    tick();
    n_checks++; if (bus.RegWrite_E !== 1'b0) $display("FAIL cmp_regwrite: got %b want 0", bus.RegWrite_E); else n_pass++;
    drive(0, 0, 0, 0, 2'b00, 4'b1110);
    tick();
    n_checks++; if (bus.Flags !== 4'b1000) $display("FAIL cmp_flags: got %b want 1000", bus.Flags); else n_pass++;
  endtask

  task automatic test_partial_update();
    drive(0, 0, 0, 0, 2'b11, 4'b1110); bus.ALUFlags = 4'b0110;
    tick();
    drive(0, 1, 0, 0, 2'b10, 4'b1110);
    tick();
    drive(0, 0, 0, 0, 2'b00, 4'b1110); bus.ALUFlags = 4'b1001;
    tick();
    n_checks++; if (bus.Flags !== 4'b1010) $display("FAIL partial_flags: got %b want 1010", bus.Flags); else n_pass++;
    drive(1, 1, 1, 0, 2'b10, 4'b0000);
    tick();
    n_checks++; if (bus.CondEx_E !== 1'b0) $display("FAIL failed_condex: got %b want 0", bus.CondEx_E); else n_pass++;
    n_checks++;
    if ({bus.PCSrc_E, bus.RegWrite_E, bus.MemWrite_E} !== 3'b000)
      $display("FAIL failed_gates: got %b want 000", {bus.PCSrc_E, bus.RegWrite_E, bus.MemWrite_E});
    else n_pass++;
    drive(0, 0, 0, 0, 2'b00, 4'b1110); bus.ALUFlags = 4'b0101;
    tick();
    n_checks++; if (bus.Flags !== 4'b1010) $display("FAIL failed_flags: got %b want 1010", bus.Flags); else n_pass++;
  endtask

  task automatic test_stall_flush();
    int hi;
    hi = 0;
    drive(0, 0, 1, 0, 2'b11, 4'b1110); bus.ALUFlags = 4'b1100;
    tick();
    if (bus.MemWrite_E === 1'b1) hi++;
    bus.stall_e = 1;
    drive(0, 0, 0, 0, 2'b00, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      bus.ALUFlags = 4'(i + 4);
      tick();
      if (bus.MemWrite_E === 1'b1) hi++;
      n_checks++; if (bus.Flags !== m_flags) $display("FAIL stall_flags_%0d: got %b want %b", i, bus.Flags, m_flags); else n_pass++;
    end
    bus.stall_e = 0; bus.ALUFlags = 4'b0011;
    tick();
    n_checks++; if (hi !== 4) $display("FAIL stall_memwrite_cycles: got %0d want 4", hi); else n_pass++;
    n_checks++; if (bus.MemWrite_E !== 1'b0) $display("FAIL stall_release_memwrite: got %b want 0", bus.MemWrite_E); else n_pass++;
    n_checks++; if (bus.Flags !== 4'b0011) $display("FAIL stall_commit_flags: got %b want 0011", bus.Flags); else n_pass++;
    drive(1, 1, 1, 0, 2'b11, 4'b1110);
    tick();
    bus.stall_e = 1; bus.flush_e = 1; bus.ALUFlags = 4'b1100;
    drive(0, 0, 0, 0, 2'b00, 4'b1110);
    tick();
    bus.stall_e = 0; bus.flush_e = 0;
    n_checks++; if (bus.Flags !== 4'b0011) $display("FAIL discard_flags: got %b want 0011", bus.Flags); else n_pass++;
    n_checks++;
    if ({bus.PCSrc_E, bus.RegWrite_E, bus.MemWrite_E, bus.CondEx_E} !== 4'b0001)
      $display("FAIL discard_bubble: got %b want 0001",
               {bus.PCSrc_E, bus.RegWrite_E, bus.MemWrite_E, bus.CondEx_E});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 4'($urandom));
      bus.ALUFlags = 4'($urandom);
      bus.stall_e = ($urandom_range(0, 3) == 0);
      bus.flush_e = ($urandom_range(0, 5) == 0);
      tick();
      n_checks++;
      if ({bus.PCSrc_E, bus.RegWrite_E, bus.MemWrite_E, bus.CondEx_E} !==
          {exp_pcsrc(), exp_regwrite(), exp_memwrite(), exp_condex()})
        $display("FAIL rand_outputs i=%0d: got %b want %b", i,
                 {bus.PCSrc_E, bus.RegWrite_E, bus.MemWrite_E, bus.CondEx_E},
                 {exp_pcsrc(), exp_regwrite(), exp_memwrite(), exp_condex()});
      else n_pass++;
      n_checks++;
      if (bus.Flags !== m_flags) $display("FAIL rand_flags i=%0d: got %b want %b", i, bus.Flags, m_flags);
      else n_pass++;
    end
    bus.stall_e = 0; bus.flush_e = 0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.stall_e = 0; bus.flush_e = 0; bus.ALUFlags = 4'b0000;
    drive(0, 0, 0, 0, 2'b00, 4'b1110);
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_cond_sweep();
    test_subs_beq();
    test_cmp_nowrite();
    test_partial_update();
    test_stall_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-stage conditional-execution unit for the pipelined ARM datapath. It registers the decode-stage control word (PCS, RegW, MemW, NoWrite, FlagW, Cond) into an execute pipeline register with stall and flush control. It holds the architectural NZCV flag register, evaluates the instruction's condition field against those flags, and gates the write enables. It is the consumer of every control signal the instruction decoder emits.

## Interface
Parameters:
- none (all widths fixed by the ISA)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_e  in  1  hold the execute register; the instruction stays in E
- flush_e  in  1  load a bubble into the execute register; has priority over stall_e
- PCS_D  in  1  decoder: PC-write request
- RegW_D  in  1  decoder: register-file write request
- MemW_D  in  1  decoder: memory write request
- NoWrite_D  in  1  decoder: flag-only op (CMP/CMN/TST/TEQ); suppresses register write
- FlagW_D  in  2  decoder: [1] updates N,Z; [0] updates C,V
- Cond_D  in  4  instruction bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the execute-stage ALU, combinational
- PCSrc_E  out  1  gated PC write
- RegWrite_E  out  1  gated register write
- MemWrite_E  out  1  gated memory write
- CondEx_E  out  1  condition passed for the instruction in E
- Flags  out  4  committed {N,Z,C,V}

## Operation
- Execute register fields: PCS, RegW, MemW, NoWrite, FlagW[1:0], Cond[3:0].
- Bubble value: all controls 0, Cond=4'b1110 (AL).
- Register update at each rising edge:
  - flush_e: load the bubble, regardless of stall_e.
  - else stall_e: hold the current contents.
  - else: capture the *_D inputs.
- CondEx_E is combinational from the E Cond field and the committed Flags:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C&!Z
  - LS 1001: !C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: !Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - 1111: 1 (treated as AL)
- Gated outputs:
  - PCSrc_E = PCS_E & CondEx_E
  - RegWrite_E = RegW_E & !NoWrite_E & CondEx_E
  - MemWrite_E = MemW_E & CondEx_E
- Flag commit happens on an edge where the E instruction retires, i.e. stall_e=0 (flush_e value irrelevant), and CondEx_E=1:
  - FlagW_E[1]: N,Z ← ALUFlags[3:2]
  - FlagW_E[0]: C,V ← ALUFlags[1:0]
  - Unselected flag bits hold their value.
- stall_e=1 and flush_e=1 together: the instruction in E is discarded. Flags do not commit and E becomes the bubble.
- Gated outputs stay asserted for every cycle an enabled instruction is held by stall_e. Downstream stages qualify them with their own stall.

## Timing
- Reset (rst_n low, asynchronous): E register = bubble, Flags = 4'b0000.
  - Hence PCSrc_E=0, RegWrite_E=0, MemWrite_E=0, CondEx_E=1.
- Decode to E latency: 1 cycle. Controls presented in cycle n drive the gated outputs in cycle n+1.
- Flag visibility:
  - Flags written by instruction i are visible to CondEx_E of instruction i+1 in the very next E cycle. No extra bubble is required.
  - ALUFlags is sampled only at the retiring edge.
- rst_n deassertion is synchronised externally. The block assumes a clean release.
- Reset mid-stall: E and Flags clear immediately, and the held instruction is lost.

## Structure
- Shared package cond_pkg:
  - localparams COND_EQ … COND_AL and COND_NV (4-bit)
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - the execute-control struct/width constant and the bubble constant
- Sub-module cond_check: purely combinational; inputs Cond[3:0] and Flags[3:0], output CondEx. It is reused later by the branch predictor verifier.
- The top level holds the execute register, the flag register, and the output gating.

## Test plan
- Reset: hold rst_n=0 mid-cycle → all outputs 0 except CondEx_E=1; Flags=0000 immediately, without a clock edge.
- Condition sweep: for each of the 16 Cond codes and each of the 16 Flags values (preloaded via a flag-setting ADDS), RegW_D=1, NoWrite_D=0 → RegWrite_E matches the table above (256 checks).
- SUBS then BEQ: first instruction FlagW_D=11, ALUFlags=0100 → Flags=0100 after retirement. Next instruction PCS_D=1, Cond=0000 → PCSrc_E=1 in the following cycle.
- CMP with NoWrite: RegW_D=1, NoWrite_D=1, FlagW_D=11, Cond=AL, ALUFlags=1000 → RegWrite_E=0, Flags=1000 next edge.
- Partial and failed update:
  - Flags=0110, FlagW_E=10, ALUFlags=1001 → Flags=1010 (C,V held).
  - Same instruction with Cond=EQ and Z=0 → Flags unchanged, all gated outputs 0.
- Stall/flush: stall_e=1 for 3 cycles with MemW=1, Cond=AL → MemWrite_E=1 for 4 cycles, and flags commit once at release. stall_e=flush_e=1 with FlagW=11 → no commit, and E becomes the bubble.
